// File: rtl/adsr_env_gen.sv
// ADSR envelope generator with a two-stage amplitude multiplier between the
// oscillator waveform stage and the delta-sigma DAC.
module adsr_env_gen #(
  parameter int C_FCK   = 48_000_000,
  parameter int C_FTICK = 48_000
) (
  input  logic        CK_i,
  input  logic        XARST_i,
  input  tri1 logic   EN_CK_i,
  input  logic        GATE_i,
  input  logic [7:0]  ATTACK_i,
  input  logic [7:0]  DECAY_i,
  input  logic [7:0]  SUSTAIN_i,
  input  logic [7:0]  RELEASE_i,
  input  logic [11:0] DAT_i,
  output logic [11:0] DAT_o,
  output logic [15:0] ENV_o,
  output logic [2:0]  STATE_o,
  output logic        BUSY_o
);

  localparam int C_TC = (C_FCK / C_FTICK) - 1;
  localparam int C_CW = (C_TC < 1) ? 1 : $clog2(C_TC + 1);
  localparam logic [C_CW-1:0] C_TC_V = C_CW'(C_TC);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [15:0]       env_q;
  logic [15:0]       env_d;
  logic [C_CW-1:0]   pre_cnt;
  logic              tick;
  logic              gate_d;
  logic              gate_armed;
  logic              rise;
  logic [16:0]       step_a;
  logic [16:0]       step_d;
  logic [16:0]       step_r;
  logic [15:0]       sus_lvl;
  logic [16:0]       atk_sum;
  logic [16:0]       dec_limit;
  logic signed [11:0] dat_s;
  logic signed [16:0] env_s;
  logic signed [28:0] prod;
  logic signed [28:0] prod_q;
  logic [11:0]       dat_q;
  logic              unused_prod_bits;

  // A gate held high through reset must be seen low once before a rise counts.
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      pre_cnt    <= '0;
      gate_d     <= 1'b0;
      gate_armed <= 1'b0;
    end else if (EN_CK_i) begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      gate_d  <= GATE_i;
      if (!GATE_i) begin
        gate_armed <= 1'b1;
      end
    end
  end

  assign tick = EN_CK_i && (pre_cnt == C_TC_V);
  assign rise = GATE_i && !gate_d && gate_armed;

  assign step_a    = 17'({ATTACK_i, 4'b0000}) + 17'd16;
  assign step_d    = 17'({DECAY_i, 4'b0000}) + 17'd16;
  assign step_r    = 17'({RELEASE_i, 4'b0000}) + 17'd16;
  assign sus_lvl   = {SUSTAIN_i, SUSTAIN_i};
  assign atk_sum   = {1'b0, env_q} + step_a;
  assign dec_limit = {1'b0, sus_lvl} + step_d;

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      state_q <= ST_IDLE;
      env_q   <= '0;
    end else if (EN_CK_i) begin
      state_q <= state_d;
      env_q   <= env_d;
    end
  end

  // Gate changes win over tick-driven level updates; ENV holds on that tick.
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    case (state_q)
      ST_IDLE: begin
        env_d = '0;
        if (rise) begin
          state_d = ST_ATTACK;
        end
      end
      ST_ATTACK: begin
        if (!GATE_i) begin
          state_d = ST_RELEASE;
        end else if (tick) begin
          if (atk_sum >= 17'h0FFFF) begin
            env_d   = 16'hFFFF;
            state_d = ST_DECAY;
          end else begin
            env_d = atk_sum[15:0];
          end
        end
      end
      ST_DECAY: begin
        if (!GATE_i) begin
          state_d = ST_RELEASE;
        end else if (tick) begin
          if ({1'b0, env_q} <= dec_limit) begin
            env_d   = sus_lvl;
            state_d = ST_SUSTAIN;
          end else begin
            env_d = env_q - step_d[15:0];
          end
        end
      end
      ST_SUSTAIN: begin
        if (!GATE_i) begin
          state_d = ST_RELEASE;
        end else if (tick) begin
          env_d = sus_lvl;
        end
      end
      ST_RELEASE: begin
        if (rise) begin
          state_d = ST_ATTACK;
        end else if (tick) begin
          if ({1'b0, env_q} <= step_r) begin
            env_d   = '0;
            state_d = ST_IDLE;
          end else begin
            env_d = env_q - step_r[15:0];
          end
        end
      end
      default: begin
        env_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    STATE_o = state_q;
    ENV_o   = env_q;
    BUSY_o  = (state_q != ST_IDLE);
  end

  // Signed sample times non-negative envelope; the floor shift keeps bits [27:16].
  assign dat_s = {~DAT_i[11], DAT_i[10:0]};
  assign env_s = {1'b0, env_q};
  assign prod  = dat_s * env_s;

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      prod_q <= '0;
      dat_q  <= 12'h800;
    end else if (EN_CK_i) begin
      prod_q <= prod;
      dat_q  <= {~prod_q[27], prod_q[26:16]};
    end
  end

  assign DAT_o            = dat_q;
  assign unused_prod_bits = ^{prod_q[28], prod_q[15:0]};

endmodule

// File: tb/tb_adsr_env_gen.sv
// Directed bench for adsr_env_gen: envelope phases, gate edge cases, clock
// enable freeze, async reset and multiplier scaling through a scoreboard.
module tb_adsr_env_gen;

  localparam int FCK   = 48_000;
  localparam int FTICK = 1_000;
  localparam int TC    = FCK / FTICK - 1;

  logic        CK_i;
  logic        XARST_i;
  logic        EN_CK_i;
  logic        GATE_i;
  logic [7:0]  ATTACK_i;
  logic [7:0]  DECAY_i;
  logic [7:0]  SUSTAIN_i;
  logic [7:0]  RELEASE_i;
  logic [11:0] DAT_i;
  logic [11:0] DAT_o;
  logic [15:0] ENV_o;
  logic [2:0]  STATE_o;
  logic        BUSY_o;

  typedef struct {
    string       tag;
    logic [11:0] dat;
  } exp_t;

  exp_t sb_q[$];
  int   n_compared = 0;
  int   n_mismatch = 0;
  int   pre_m      = 0;
  int   tick_count = 0;

  adsr_env_gen #(
    .C_FCK   (FCK),
    .C_FTICK (FTICK)
  ) dut (
    .CK_i      (CK_i),
    .XARST_i   (XARST_i),
    .EN_CK_i   (EN_CK_i),
    .GATE_i    (GATE_i),
    .ATTACK_i  (ATTACK_i),
    .DECAY_i   (DECAY_i),
    .SUSTAIN_i (SUSTAIN_i),
    .RELEASE_i (RELEASE_i),
    .DAT_i     (DAT_i),
    .DAT_o     (DAT_o),
    .ENV_o     (ENV_o),
    .STATE_o   (STATE_o),
    .BUSY_o    (BUSY_o)
  );

  initial CK_i = 1'b0;
  always #5 CK_i = ~CK_i;

  // Independent tick-rate reference so waits line up with envelope updates.
  always @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      pre_m <= 0;
    end else if (EN_CK_i) begin
      if (pre_m == TC) begin
        pre_m      <= 0;
        tick_count <= tick_count + 1;
      end else begin
        pre_m <= pre_m + 1;
      end
    end
  end

  function automatic logic [11:0] dat_model(input logic [11:0] d, input logic [15:0] e);
    int s;
    int p;
    int q;
    s = int'(d) - 2048;
    p = s * int'(e);
    q = p >>> 16;
    return 12'(q + 2048);
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatch++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CK_i);
  endtask

  task automatic wait_ticks(input int n);
    int target;
    int guard;
    target = tick_count + n;
    guard  = 0;
    while (tick_count < target && guard < (n + 1) * (TC + 1) + 10) begin
      @(negedge CK_i);
      guard++;
    end
    if (tick_count < target) begin
      n_compared++;
      n_mismatch++;
      $display("[TB] FAIL wait_ticks timeout observed=%0d expected=%0d", tick_count, target);
    end
  endtask

  task automatic apply_stimulus(input string tag, input logic [11:0] dat, input logic [15:0] env_exp);
    exp_t e;
    DAT_i = dat;
    e.tag = tag;
    e.dat = dat_model(dat, env_exp);
    sb_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_compared++;
      n_mismatch++;
      $display("[TB] FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb_q.pop_front();
      check_output(e.tag, 32'(DAT_o), 32'(e.dat));
    end
  endtask

  initial begin
    XARST_i   = 1'b1;
    EN_CK_i   = 1'b1;
    GATE_i    = 1'b0;
    ATTACK_i  = 8'hFF;
    DECAY_i   = 8'hFF;
    SUSTAIN_i = 8'h80;
    RELEASE_i = 8'h00;
    DAT_i     = 12'h800;
    #2 XARST_i = 1'b0;
    step(3);
    check_output("rst_state", 32'(STATE_o), 32'd0);
    check_output("rst_env", 32'(ENV_o), 32'h0);
    check_output("rst_dat", 32'(DAT_o), 32'h800);
    check_output("rst_busy", 32'(BUSY_o), 32'd0);
    XARST_i = 1'b1;

    apply_stimulus("idle_scale_env0", 12'hFFF, 16'h0000);
    step(2);
    pop_check();
    for (int i = 0; i < 4; i++) begin
      step(250);
      check_output("idle_state", 32'(STATE_o), 32'd0);
      check_output("idle_env", 32'(ENV_o), 32'h0);
      check_output("idle_dat", 32'(DAT_o), 32'h800);
      check_output("idle_busy", 32'(BUSY_o), 32'd0);
    end
    DAT_i = 12'h800;

    GATE_i = 1'b1;
    step(1);
    check_output("atk_enter_state", 32'(STATE_o), 32'd1);
    check_output("atk_enter_busy", 32'(BUSY_o), 32'd1);
    wait_ticks(8);
    check_output("atk_mid_env", 32'(ENV_o), 32'h8000);

    apply_stimulus("scale_8000_fff", 12'hFFF, 16'h8000);
    step(1);
    check_output("latency_hold", 32'(DAT_o), 32'h800);
    step(1);
    pop_check();
    check_output("scale_8000_fff_const", 32'(DAT_o), 32'hBFF);
    apply_stimulus("scale_8000_000", 12'h000, 16'h8000);
    step(2);
    pop_check();
    check_output("scale_8000_000_const", 32'(DAT_o), 32'h400);

    EN_CK_i = 1'b0;
    DAT_i   = 12'hFFF;
    step(200);
    check_output("freeze_env", 32'(ENV_o), 32'h8000);
    check_output("freeze_state", 32'(STATE_o), 32'd1);
    check_output("freeze_dat", 32'(DAT_o), 32'h400);
    EN_CK_i = 1'b1;
    DAT_i   = 12'h800;

    wait_ticks(6);
    check_output("atk_tick14_env", 32'(ENV_o), 32'hE000);
    step(TC);
    check_output("atk_pre_tick15_env", 32'(ENV_o), 32'hE000);
    step(1);
    check_output("atk_tick15_env", 32'(ENV_o), 32'hF000);
    check_output("atk_tick15_state", 32'(STATE_o), 32'd1);
    wait_ticks(1);
    check_output("atk_top_env", 32'(ENV_o), 32'hFFFF);
    check_output("atk_top_state", 32'(STATE_o), 32'd2);

    for (int k = 1; k <= 7; k++) begin
      wait_ticks(1);
      check_output("dec_env", 32'(ENV_o), 32'(16'hFFFF - 16'(k * 4096)));
    end
    check_output("dec_state", 32'(STATE_o), 32'd2);
    wait_ticks(1);
    check_output("sus_enter_env", 32'(ENV_o), 32'h8080);
    check_output("sus_enter_state", 32'(STATE_o), 32'd3);
    apply_stimulus("scale_8080_fff", 12'hFFF, 16'h8080);
    step(2);
    pop_check();
    DAT_i = 12'h800;

    SUSTAIN_i = 8'h40;
    wait_ticks(1);
    check_output("sus_follow_env", 32'(ENV_o), 32'h4040);
    SUSTAIN_i = 8'h80;
    wait_ticks(1);
    check_output("sus_back_env", 32'(ENV_o), 32'h8080);

    RELEASE_i = 8'h00;
    GATE_i    = 1'b0;
    step(1);
    check_output("rel_enter_state", 32'(STATE_o), 32'd4);
    check_output("rel_enter_env", 32'(ENV_o), 32'h8080);
    wait_ticks(1);
    check_output("rel_step1_env", 32'(ENV_o), 32'h8070);
    wait_ticks(1);
    check_output("rel_step2_env", 32'(ENV_o), 32'h8060);
    RELEASE_i = 8'hFF;
    wait_ticks(8);
    check_output("rel_low_env", 32'(ENV_o), 32'h0060);
    check_output("rel_low_state", 32'(STATE_o), 32'd4);
    wait_ticks(1);
    check_output("rel_done_env", 32'(ENV_o), 32'h0);
    check_output("rel_done_state", 32'(STATE_o), 32'd0);
    check_output("rel_done_busy", 32'(BUSY_o), 32'd0);

    GATE_i = 1'b1;
    step(1);
    check_output("atk2_state", 32'(STATE_o), 32'd1);
    wait_ticks(6);
    check_output("atk2_env", 32'(ENV_o), 32'h6000);
    step(TC);
    GATE_i = 1'b0;
    step(1);
    check_output("fall_on_tick_state", 32'(STATE_o), 32'd4);
    check_output("fall_on_tick_env", 32'(ENV_o), 32'h6000);
    wait_ticks(2);
    check_output("rel2_env", 32'(ENV_o), 32'h4000);
    GATE_i = 1'b1;
    step(1);
    check_output("retrig_state", 32'(STATE_o), 32'd1);
    check_output("retrig_env", 32'(ENV_o), 32'h4000);
    wait_ticks(1);
    check_output("retrig_up_env", 32'(ENV_o), 32'h5000);
    wait_ticks(11);
    check_output("atk3_top_env", 32'(ENV_o), 32'hFFFF);
    check_output("atk3_top_state", 32'(STATE_o), 32'd2);
    wait_ticks(1);
    check_output("dec3_env", 32'(ENV_o), 32'hEFFF);
    apply_stimulus("scale_efff_fff", 12'hFFF, 16'hEFFF);
    step(2);
    pop_check();

    #2 XARST_i = 1'b0;
    #1;
    check_output("async_rst_state", 32'(STATE_o), 32'd0);
    check_output("async_rst_env", 32'(ENV_o), 32'h0);
    check_output("async_rst_dat", 32'(DAT_o), 32'h800);
    check_output("async_rst_busy", 32'(BUSY_o), 32'd0);
    step(2);
    XARST_i = 1'b1;
    DAT_i   = 12'h800;
    step(100);
    check_output("gate_held_state", 32'(STATE_o), 32'd0);
    check_output("gate_held_env", 32'(ENV_o), 32'h0);
    GATE_i = 1'b0;
    step(2);
    GATE_i = 1'b1;
    step(1);
    check_output("rearm_state", 32'(STATE_o), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
